pavana_slave_ooo_mem: RTL and testbench



---
 rtl/pavana_slave_ooo_mem.sv | 131 +++++++++++++
 tb/tb_pavana_slave_ooo_mem.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pavana_slave_ooo_mem.sv
// Tagged out-of-order memory endpoint with address-dependent read latency.
// Define PAVANA_SLAVE_FIXLAT_EN for a fixed latency, in-order return baseline.
module pavana_slave_ooo_mem #(
    parameter int AW       = 10,
    parameter int DEPTH    = 4,
    parameter int LAT_BASE = 2,
    parameter int TIDW     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req,
    input  logic [31:0]     addr,
    input  logic            cmd,
    input  logic [TIDW-1:0] reqtid,
    input  logic [31:0]     wdata,
    output logic            ack,
    output logic            resp,
    output logic [TIDW-1:0] resptid,
    output logic [31:0]     rdata
);
    localparam int IW = $clog2(DEPTH);

    logic [31:0] mem_q [2**AW];

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0][TIDW-1:0] tid_q, tid_d;
    logic [DEPTH-1:0][31:0]     data_q, data_d;
    logic [DEPTH-1:0][2:0]      cnt_q, cnt_d;

    logic            resp_q, resp_d;
    logic [TIDW-1:0] resptid_q, resptid_d;
    logic [31:0]     rdata_q, rdata_d;

    logic          free_any, rdy_any;
    logic [IW-1:0] free_idx, rdy_idx;
    logic [AW-1:0] widx;
    logic [3:0]    lat_m1;
    logic [2:0]    lat_cnt;
    logic          rd_acc, wr_acc;
    logic          unused_addr;

    assign widx        = addr[AW+1:2];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

`ifdef PAVANA_SLAVE_FIXLAT_EN
    assign lat_m1 = 4'(LAT_BASE - 1);
`else
    assign lat_m1 = 4'(LAT_BASE - 1) + {2'b00, addr[3:2]};
`endif
    assign lat_cnt = lat_m1[3] ? 3'd7 : lat_m1[2:0];

    // Downward scan leaves the lowest matching index in each result.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        rdy_any  = 1'b0;
        rdy_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
            if (valid_q[i] && cnt_q[i] == 3'd0) begin
                rdy_any = 1'b1;
                rdy_idx = IW'(i);
            end
        end
    end

    assign ack    = rst_i && free_any;
    assign wr_acc = req && ack && cmd;
    assign rd_acc = req && ack && !cmd;

    always_comb begin
        valid_d   = valid_q;
        tid_d     = tid_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        resp_d    = 1'b0;
        resptid_d = resptid_q;
        rdata_d   = rdata_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && cnt_q[i] != 3'd0) begin
                cnt_d[i] = cnt_q[i] - 3'd1;
            end
        end
        if (rdy_any) begin
            valid_d[rdy_idx] = 1'b0;
            resp_d           = 1'b1;
            resptid_d        = tid_q[rdy_idx];
            rdata_d          = data_q[rdy_idx];
        end
        // A ready slot is valid, so the free slot is never the one retiring.
        if (rd_acc) begin
            valid_d[free_idx] = 1'b1;
            tid_d[free_idx]   = reqtid;
            data_d[free_idx]  = mem_q[widx];
            cnt_d[free_idx]   = lat_cnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q   <= '0;
            tid_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            resp_q    <= 1'b0;
            resptid_q <= '0;
            rdata_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            tid_q     <= tid_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            resptid_q <= resptid_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[widx] <= wdata;
        end
    end

    assign resp    = resp_q;
    assign resptid = resptid_q;
    assign rdata   = rdata_q;
endmodule

// File: tb/tb_pavana_slave_ooo_mem.sv
// Scoreboard bench for pavana_slave_ooo_mem: ready-time reference model,
// decoupled response monitor, directed and random phases.
module tb_pavana_slave_ooo_mem;
    localparam int DEPTH    = 4;
    localparam int LAT_BASE = 2;

    logic        clk = 1'b0;
    logic        rst_i, req, cmd;
    logic [31:0] addr, wdata;
    logic [1:0]  reqtid;
    logic        ack, resp;
    logic [1:0]  resptid;
    logic [31:0] rdata;

    pavana_slave_ooo_mem #(
        .AW(10), .DEPTH(DEPTH), .LAT_BASE(LAT_BASE), .TIDW(2)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req(req), .addr(addr), .cmd(cmd),
        .reqtid(reqtid), .wdata(wdata), .ack(ack), .resp(resp),
        .resptid(resptid), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  tid;
        logic [31:0] data;
        int          when;
    } exp_t;
    exp_t sb[$];

    bit          m_v[DEPTH];
    logic [1:0]  m_tid[DEPTH];
    logic [31:0] m_data[DEPTH];
    int          m_rdy[DEPTH];
    logic [31:0] m_mem[16];

    int   last_resp[4];
    logic last_ack;
    bit   prev_rst = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input logic [31:0] a);
`ifdef PAVANA_SLAVE_FIXLAT_EN
        return LAT_BASE;
`else
        return LAT_BASE + int'(a[3:2]);
`endif
    endfunction

    function automatic logic [31:0] mka(input int w);
        logic [31:0] a;
        a = $urandom();
        a[11:2] = 10'(w);
        return a;
    endfunction

    // One cycle: drive inputs, check ack, advance the reference model.
    task automatic step(input logic r, input logic rq, input logic c,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] t, output int tc);
        int sel;
        int fi;
        bit eack;
        @(negedge clk);
        rst_i = r; req = rq; cmd = c; addr = a; wdata = wd; reqtid = t;
        tc = cyc;
        #1;
        if (prev_rst) begin
            chk("rst_resp", 32'(resp), 32'd0);
            chk("rst_resptid", 32'(resptid), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
        end
        fi = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) fi = i;
        eack = r && (fi >= 0);
        chk("ack", 32'(ack), 32'(eack));
        last_ack = ack;
        if (!r) begin
            for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
        end else begin
            sel = -1;
            for (int i = DEPTH - 1; i >= 0; i--)
                if (m_v[i] && m_rdy[i] <= cyc) sel = i;
            if (sel >= 0) begin
                sb.push_back('{m_tid[sel], m_data[sel], cyc + 1});
                m_v[sel] = 1'b0;
            end
            if (rq && eack) begin
                if (c) begin
                    m_mem[a[5:2]] = wd;
                end else begin
                    m_v[fi]    = 1'b1;
                    m_tid[fi]  = t;
                    m_data[fi] = m_mem[a[5:2]];
                    m_rdy[fi]  = cyc + lat(a);
                end
            end
        end
        prev_rst = !r;
    endtask

    task automatic idle(input int n);
        int tc;
        repeat (n) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, tc);
    endtask

    task automatic clr_last();
        for (int i = 0; i < 4; i++) last_resp[i] = -1;
    endtask

    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (resp === 1'b1) begin
                last_resp[resptid] = cyc;
                if (sb.size() == 0 || sb[0].when != cyc) begin
                    checks++;
                    errs++;
                    $display("FAIL resp_unexpected: got tid %0d at cycle %0d, expected none",
                             resptid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("resptid", 32'(resptid), 32'(e.tid));
                    chk("rdata", rdata, e.data);
                end
            end else if (sb.size() > 0 && sb[0].when <= cyc) begin
                checks++;
                errs++;
                $display("FAIL resp_missing: got none at cycle %0d, expected tid %0d",
                         cyc, sb[0].tid);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int t0;
        int tc;
        rst_i = 1'b0; req = 1'b0; cmd = 1'b0;
        addr = '0; wdata = '0; reqtid = '0;
        clr_last();

        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 2'd0, tc);

        for (int w = 0; w < 16; w++)
            step(1'b1, 1'b1, 1'b1, mka(w), $urandom(), 2'd0, tc);

        clr_last();
        step(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 2'd0, tc);
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 2'd1, t0);
        idle(8);
        chk("readback_cyc", last_resp[1], t0 + 3);

        clr_last();
        step(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0, 2'd0, t0);
        step(1'b1, 1'b1, 1'b0, 32'h00, 32'h0, 2'd1, tc);
        idle(8);
`ifdef PAVANA_SLAVE_FIXLAT_EN
        chk("order_tid0", last_resp[0], t0 + 3);
        chk("order_tid1", last_resp[1], t0 + 4);
`else
        chk("ooo_tid1", last_resp[1], t0 + 4);
        chk("ooo_tid0", last_resp[0], t0 + 6);
`endif

        clr_last();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0, 2'(k), tc);
            if (k == 0) t0 = tc;
        end
        step(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0, 2'd0, tc);
`ifndef PAVANA_SLAVE_FIXLAT_EN
        chk("full_ack", 32'(last_ack), 32'd0);
`endif
        step(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0, 2'd0, tc);
        idle(2);
`ifndef PAVANA_SLAVE_FIXLAT_EN
        chk("full_first_resp", last_resp[0], t0 + 6);
        chk("full_ack_back", 32'(last_ack), 32'd1);
`endif
        idle(10);

        clr_last();
        step(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0, 2'd0, t0);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 32'h04, 32'h0, 2'd1, tc);
        idle(8);
`ifdef PAVANA_SLAVE_FIXLAT_EN
        chk("cont_tid0", last_resp[0], t0 + 3);
        chk("cont_tid1", last_resp[1], t0 + 5);
`else
        chk("cont_tid0", last_resp[0], t0 + 6);
        chk("cont_tid1", last_resp[1], t0 + 7);
`endif

        clr_last();
        step(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0, 2'd0, t0);
        step(1'b1, 1'b1, 1'b0, 32'h00, 32'h0, 2'd1, tc);
        step(1'b1, 1'b1, 1'b0, 32'h04, 32'h0, 2'd2, tc);
        idle(8);
`ifdef PAVANA_SLAVE_FIXLAT_EN
        chk("seq_tid0", last_resp[0], t0 + 3);
        chk("seq_tid1", last_resp[1], t0 + 4);
        chk("seq_tid2", last_resp[2], t0 + 5);
`else
        chk("seq_tid1", last_resp[1], t0 + 4);
        chk("seq_tid0", last_resp[0], t0 + 6);
        chk("seq_tid2", last_resp[2], t0 + 7);
`endif

        clr_last();
        step(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0, 2'd3, tc);
        idle(1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, tc);
        idle(8);
        chk("rst_discard", last_resp[3], 32'hFFFF_FFFF);

        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 49) != 0),
                 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 9) < 3),
                 mka(int'($urandom_range(0, 15))),
                 $urandom(), 2'($urandom_range(0, 3)), tc);
        end
        idle(12);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
